bgr_startup_ctrl: RTL

//  Digital start-up sequencer driving the bandgap's porst start-up input (upstream of the BGR top).

---
 rtl/bgr_ctrl_pkg.sv | 34 +++
 rtl/bgr_sync2.sv | 24 ++
 rtl/bgr_startup_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bgr_ctrl_pkg.sv
// Shared types and default timing for the bandgap start-up sequencer.
// Also provides counter sizing helpers so every counter saturates instead of wrapping.
package bgr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    SETTLE,
    CHECK,
    READY,
    FAULT
  } bgr_state_t;

  localparam int unsigned KICK_CYCLES_DEF    = 16;
  localparam int unsigned SETTLE_CYCLES_DEF  = 256;
  localparam int unsigned DEBOUNCE_DEF       = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned MAX_RETRIES_DEF    = 3;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    int unsigned w;
    w = $clog2(maxval + 1);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous comparator verdict.
module bgr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kicks the core via porst, waits, debounces vbg_ok,
// retries a bounded number of times and re-kicks if the reference drops while ready.
module bgr_startup_ctrl
  import bgr_ctrl_pkg::*;
#(
  parameter int unsigned KICK_CYCLES    = KICK_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned DEBOUNCE       = DEBOUNCE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEF,
  localparam int unsigned RW            = cnt_width(MAX_RETRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  input  logic          vbg_ok_async,
  output logic          porst,
  output logic          bgr_ready,
  output logic          bgr_fault,
  output logic [RW-1:0] retry_cnt
);

  localparam int unsigned TW = cnt_width(max3(KICK_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES));
  localparam int unsigned DW = cnt_width(DEBOUNCE);

  localparam logic [TW-1:0] KICK_LOAD    = TW'(KICK_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DBC_LAST     = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  bgr_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] dbc_q, dbc_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          porst_q, ready_q, fault_q;
  logic          enter;
  logic          ok_s;

  bgr_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (vbg_ok_async),
    .q_o (ok_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    dbc_d   = dbc_q;
    enter   = 1'b0;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;

    if (!en) begin
      enter   = (state_q != IDLE);
      state_d = IDLE;
      retry_d = '0;
    end else if (restart && state_q != IDLE) begin
      enter   = 1'b1;
      state_d = KICK;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          enter   = 1'b1;
          state_d = KICK;
        end
        KICK: begin
          if (timer_q == '0) begin
            enter   = 1'b1;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (timer_q == '0) begin
            enter   = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          // The current sample counts, so the DEBOUNCE-th good cycle moves to READY directly;
          // a debounce success on the timeout cycle takes precedence.
          if (ok_s) begin
            if (dbc_q == DBC_LAST) begin
              enter   = 1'b1;
              state_d = READY;
            end else begin
              dbc_d = dbc_q + DW'(1);
            end
          end else begin
            dbc_d = '0;
          end
          if (!enter && timer_q == '0) begin
            enter = 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = KICK;
              retry_d = retry_q + RW'(1);
            end
          end
        end
        READY: begin
          if (!ok_s) begin
            if (dbc_q == DBC_LAST) begin
              enter   = 1'b1;
              state_d = KICK;
              retry_d = '0;
            end else begin
              dbc_d = dbc_q + DW'(1);
            end
          end else begin
            dbc_d = '0;
          end
        end
        FAULT: begin
        end
        default: begin
          enter   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    if (enter) begin
      dbc_d = '0;
      case (state_d)
        KICK:    timer_d = KICK_LOAD;
        SETTLE:  timer_d = SETTLE_LOAD;
        CHECK:   timer_d = TIMEOUT_LOAD;
        default: timer_d = '0;
      endcase
    end
  end

  // Outputs decode the next state so they change with, not after, the state flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      dbc_q   <= '0;
      retry_q <= '0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dbc_q   <= dbc_d;
      retry_q <= retry_d;
      porst_q <= (state_d == KICK);
      ready_q <= (state_d == READY);
      fault_q <= (state_d == FAULT);
    end
  end

  assign porst     = porst_q;
  assign bgr_ready = ready_q;
  assign bgr_fault = fault_q;
  assign retry_cnt = retry_q;

endmodule
